// File: rtl/trace_pkg.sv
// Shared types and constants for the write-back retirement trace buffer.
// Entries carry a fixed-width timestamp field; the top zero-extends its counter into it.
package trace_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [1:0]  MODE_OFF    = 2'b00;
  localparam logic [1:0]  MODE_REGW   = 2'b01;
  localparam int          CYCLE_W_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            instruction;
    logic [31:0]            data;
    logic [4:0]             rd;
    logic [CYCLE_W_MAX-1:0] cycle;
  } trace_entry_t;

  // Mode 01 keeps architectural register writes; modes 1x keep every non-bubble instruction.
  function automatic logic qualifies(input logic [1:0]  mode,
                                     input logic        regwrite,
                                     input logic [4:0]  rd,
                                     input logic [31:0] instr);
    logic q;
    q = 1'b0;
    if (mode == MODE_REGW)
      q = regwrite && (rd != 5'd0);
    else if (mode != MODE_OFF)
      q = (instr != 32'h0) && (instr != NOP_INSTR);
    return q;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO for trace entries with selectable full policy.
// flush wins over push and pop; drop_o flags a push that could not be stored normally.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  trace_entry_t           entry_i,
  input  logic                   pop_i,
  output trace_entry_t           head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  trace_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full, empty, do_pop, wr_en;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LW'(DEPTH));
  assign do_pop = pop_i & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    wr_en   = 1'b0;
    drop_o  = 1'b0;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_i && (!full || do_pop)) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + AW'(1);
      end else if (push_i) begin
        drop_o = 1'b1;
        // When full, wptr == rptr, so overwriting lands on the oldest slot.
        if (OVERWRITE) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + AW'(1);
          rptr_d = rptr_q + AW'(1);
        end
      end
      if (do_pop)
        rptr_d = rptr_q + AW'(1);
      if (wr_en && !do_pop && !full)
        level_d = level_q + LW'(1);
      else if (do_pop && !push_i)
        level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wptr_q] <= entry_i;
  end

  assign valid_o = ~empty;
  assign head_o  = empty ? '0 : mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Retirement trace buffer: filters WB-stage instructions, timestamps them, and queues them
// for draining. WB is sampled into one register stage, so a push lands one edge after sampling.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CYCLE_W   = 32,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            wb_pc,
  input  logic [31:0]            wb_instruction,
  input  logic [31:0]            wb_write_data,
  input  logic [4:0]             wb_rd_addr,
  input  logic                   wb_RegWrite,
  input  logic [1:0]             trace_mode,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [31:0]            trig_pc,
  input  logic [15:0]            stop_count,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instruction,
  output logic [31:0]            out_data,
  output logic [4:0]             out_rd,
  output logic [CYCLE_W-1:0]     out_cycle,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_count,
  output logic [1:0]             state
);

  trace_state_t     state_q, state_d;
  logic [15:0]      cnt_q, cnt_d, cnt_inc;
  logic [CYCLE_W-1:0] cyc_q;
  logic [15:0]      drop_q;
  logic             push_q, push_d;
  trace_entry_t     entry_q, head;
  logic             qual, trig_hit, fifo_drop;
  logic             unused_cyc;

  assign qual     = qualifies(trace_mode, wb_RegWrite, wb_rd_addr, wb_instruction);
  assign trig_hit = qual && (wb_pc == trig_pc);
  assign cnt_inc  = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push_d  = 1'b0;
    if (arm) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (!trig_en) begin
            state_d = ST_CAPTURE;
          end else if (trig_hit) begin
            push_d  = 1'b1;
            cnt_d   = 16'd1;
            state_d = (stop_count == 16'd1) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (qual) begin
            push_d = 1'b1;
            cnt_d  = cnt_inc;
            if ((stop_count != 16'd0) && (cnt_inc == stop_count))
              state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      push_q  <= 1'b0;
      entry_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_q + CYCLE_W'(1);
      // flush also cancels the entry still in the sample stage
      push_q  <= push_d & ~flush;
      if (push_d) begin
        entry_q.pc          <= wb_pc;
        entry_q.instruction <= wb_instruction;
        entry_q.data        <= wb_write_data;
        entry_q.rd          <= wb_rd_addr;
        entry_q.cycle       <= CYCLE_W_MAX'(cyc_q);
      end
      if (arm)
        drop_q <= '0;
      else if (fifo_drop && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 16'd1;
    end
  end

  trace_fifo #(
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push_q),
    .entry_i (entry_q),
    .pop_i   (out_ready),
    .head_o  (head),
    .valid_o (out_valid),
    .level_o (level),
    .drop_o  (fifo_drop)
  );

  assign out_pc          = head.pc;
  assign out_instruction = head.instruction;
  assign out_data        = head.data;
  assign out_rd          = head.rd;
  assign out_cycle       = head.cycle[CYCLE_W-1:0];
  assign unused_cyc      = ^head.cycle;
  assign drop_count      = drop_q;
  assign state           = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: two DEPTH=4 instances (drop-new and overwrite-oldest)
// share all stimulus; expected values are hand-derived per step.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_pc, wb_instruction, wb_write_data, trig_pc;
  logic [4:0]  wb_rd_addr;
  logic        wb_RegWrite, arm, trig_en, flush, out_ready;
  logic [1:0]  trace_mode;
  logic [15:0] stop_count;

  logic        v0, v1;
  logic [31:0] pc0, pc1, ins0, ins1, dat0, dat1, cyc0, cyc1;
  logic [4:0]  rd0, rd1;
  logic [2:0]  lvl0, lvl1;
  logic [15:0] drp0, drp1;
  logic [1:0]  st0, st1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(4), .CYCLE_W(32), .OVERWRITE(1'b0)) u0 (
    .clk(clk), .reset(reset), .wb_pc(wb_pc), .wb_instruction(wb_instruction),
    .wb_write_data(wb_write_data), .wb_rd_addr(wb_rd_addr), .wb_RegWrite(wb_RegWrite),
    .trace_mode(trace_mode), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .stop_count(stop_count), .flush(flush), .out_valid(v0), .out_ready(out_ready),
    .out_pc(pc0), .out_instruction(ins0), .out_data(dat0), .out_rd(rd0), .out_cycle(cyc0),
    .level(lvl0), .drop_count(drp0), .state(st0)
  );

  wb_trace_buffer #(.DEPTH(4), .CYCLE_W(32), .OVERWRITE(1'b1)) u1 (
    .clk(clk), .reset(reset), .wb_pc(wb_pc), .wb_instruction(wb_instruction),
    .wb_write_data(wb_write_data), .wb_rd_addr(wb_rd_addr), .wb_RegWrite(wb_RegWrite),
    .trace_mode(trace_mode), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .stop_count(stop_count), .flush(flush), .out_valid(v1), .out_ready(out_ready),
    .out_pc(pc1), .out_instruction(ins1), .out_data(dat1), .out_rd(rd1), .out_cycle(cyc1),
    .level(lvl1), .drop_count(drp1), .state(st1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] data,
                    input logic [4:0] rd, input logic rw);
    wb_pc          = pc;
    wb_instruction = instr;
    wb_write_data  = data;
    wb_rd_addr     = rd;
    wb_RegWrite    = rw;
  endtask

  task automatic bubble();
    wb(32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; bubble(); trace_mode = 2'b00; arm = 1'b0; trig_en = 1'b0;
    trig_pc = 32'h0; stop_count = 16'd0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_state", st0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_level", lvl0, 0);
    chk("rst_drop", drp0, 0);
    chk("rst_pc", pc0, 0);
    chk("rst_cycle", cyc0, 0);

    // cycle 0: arm with immediate capture, register-write mode
    reset = 1'b0; arm = 1'b1; trace_mode = 2'b01;
    step(); arm = 1'b0;
    chk("arm_state", st0, 1);
    step();
    chk("capture_state", st0, 2);
    step();
    wb(32'h100, 32'h0050_0093, 32'd5, 5'd1, 1'b1);   // addi x1,x0,5 in cycle 3
    step(); bubble();
    chk("basic_latency_valid", v0, 0);
    step();
    chk("basic_valid", v0, 1);
    chk("basic_pc", pc0, 32'h100);
    chk("basic_rd", rd0, 1);
    chk("basic_data", dat0, 5);
    chk("basic_cycle", cyc0, 3);
    chk("basic_level", lvl0, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("basic_pop_level", lvl0, 0);
    chk("basic_pop_valid", v0, 0);

    // sw, beq, nop in mode 01: nothing writes a nonzero register
    wb(32'h200, 32'h0020_A223, 32'h0, 5'd4, 1'b0); step();
    wb(32'h204, 32'h0000_0463, 32'h0, 5'd8, 1'b0); step();
    wb(32'h208, 32'h0000_0013, 32'h0, 5'd0, 1'b1); step();
    bubble(); step(); step();
    chk("mode01_level", lvl0, 0);
    trace_mode = 2'b10;
    wb(32'h300, 32'h0020_A223, 32'h0, 5'd4, 1'b0); step();
    wb(32'h304, 32'h0000_0463, 32'h0, 5'd8, 1'b0); step();
    wb(32'h308, 32'h0000_0013, 32'h0, 5'd0, 1'b1); step();
    bubble(); step();
    chk("mode10_level", lvl0, 2);
    chk("mode10_head_pc", pc0, 32'h300);
    chk("mode10_head_instr", ins0, 32'h0020_A223);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("mode10_second_pc", pc0, 32'h304);
    chk("mode10_second_instr", ins0, 32'h0000_0463);
    chk("mode10_second_level", lvl0, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("mode10_empty", v0, 0);

    // trigger at pc 0x10, three-entry window
    arm = 1'b1; trig_en = 1'b1; trig_pc = 32'h10; stop_count = 16'd3;
    step(); arm = 1'b0;
    chk("trig_armed", st0, 1);
    for (int i = 0; i < 6; i++) begin
      wb(32'h8 + 32'(4 * i), 32'h0010_0093, 32'(i), 5'd1, 1'b1);
      step();
      if (i == 1) chk("trig_wait_state", st0, 1);
      if (i == 2) chk("trig_hit_state", st0, 2);
      if (i == 4) chk("trig_done_state", st0, 3);
    end
    bubble(); step();
    chk("trig_level", lvl0, 3);
    chk("trig_first_pc", pc0, 32'h10);
    chk("trig_first_data", dat0, 2);
    chk("trig_drop", drp0, 0);
    wb(32'h10, 32'h0010_0093, 32'h9, 5'd1, 1'b1); step(); bubble(); step();
    chk("done_ignores_level", lvl0, 3);
    chk("done_hold_state", st0, 3);
    out_ready = 1'b1; step();
    chk("trig_pc2", pc0, 32'h14);
    step();
    chk("trig_pc3", pc0, 32'h18);
    step(); out_ready = 1'b0;
    chk("trig_drained", lvl0, 0);

    // overflow: six pushes into four slots, no draining
    arm = 1'b1; trig_en = 1'b0; stop_count = 16'd0; trace_mode = 2'b10;
    step(); arm = 1'b0; step();
    chk("ovf_state", st0, 2);
    for (int i = 0; i < 6; i++) begin
      wb(32'h40 + 32'(4 * i), 32'h0010_0093, 32'h100 + 32'(i), 5'd1, 1'b1);
      step();
    end
    bubble(); step(); step();
    chk("ovf0_level", lvl0, 4);
    chk("ovf0_drop", drp0, 2);
    chk("ovf0_head", pc0, 32'h40);
    chk("ovf1_level", lvl1, 4);
    chk("ovf1_drop", drp1, 2);
    chk("ovf1_head", pc1, 32'h48);
    chk("ovf1_head_data", dat1, 32'h102);

    // full boundary: push and pop land on the same edge
    wb(32'h58, 32'h0010_0093, 32'h106, 5'd1, 1'b1); step();
    bubble(); out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("full_pp0_level", lvl0, 4);
    chk("full_pp0_drop", drp0, 2);
    chk("full_pp0_head", pc0, 32'h44);
    chk("full_pp1_level", lvl1, 4);
    chk("full_pp1_drop", drp1, 2);
    chk("full_pp1_head", pc1, 32'h4C);

    // flush alongside a qualifying instruction
    wb(32'h60, 32'h0010_0093, 32'h7, 5'd1, 1'b1); flush = 1'b1; step();
    flush = 1'b0; bubble(); step();
    chk("flush0_level", lvl0, 0);
    chk("flush1_level", lvl1, 0);
    chk("flush_valid", v0, 0);
    chk("flush_drop_kept", drp0, 2);
    chk("flush_state_kept", st0, 2);

    // reset while capturing
    wb(32'h70, 32'h0010_0093, 32'h8, 5'd1, 1'b1); reset = 1'b1; step();
    chk("midrst_state", st0, 0);
    chk("midrst_valid", v0, 0);
    chk("midrst_level", lvl0, 0);
    chk("midrst_drop", drp0, 0);
    bubble(); reset = 1'b0; arm = 1'b1;
    step(); arm = 1'b0; step();
    wb(32'h80, 32'h0010_0093, 32'h9, 5'd1, 1'b1); step();
    bubble(); step();
    chk("restart_valid", v0, 1);
    chk("restart_pc", pc0, 32'h80);
    chk("restart_cycle", cyc0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
